// File: rtl/vs_uart_rx.sv
// ---------------------------------------------------------------------------
// vs_uart_rx -- asynchronous serial receiver with 16x oversampling.
//
// Receives one frame at a time from an idle-high serial line. The line is
// resynchronised by a 2-flop synchroniser. Each bit is sampled once, at
// oversample phase 7, which is the middle of the bit.
//
// Frame format is selected at compile time by macro VS_UART_RX_PARITY_EN:
//   defined   : 8E1. A PARITY state follows the data bits, and RX_DATA[8]
//               carries the even-parity check result.
//   undefined : 8N1. There is no PARITY state, STOP follows DATA directly,
//               and RX_DATA[8] is always 0.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        line rate in bit/s
//
// Ports
//   CLK         system clock, rising edge
//   SYS_NRST    asynchronous active-low reset
//   RXD         asynchronous serial input, idle high
//   RX_DATA_EN  one-CLK strobe; RX_DATA holds a newly completed frame
//   RX_DATA     {FRM_ERR, PAR_ERR, DATA[7:0]}; held between strobes
//   RX_BUSY     low only while the receiver is idle
// ---------------------------------------------------------------------------
module vs_uart_rx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       CLK,
  input  logic       SYS_NRST,
  input  logic       RXD,
  output logic       RX_DATA_EN,
  output logic [9:0] RX_DATA,
  output logic       RX_BUSY
);

  // Clocks per oversample tick. The value is clamped to at least 1 so that
  // very low CLK_FREQ/BAUD ratios still elaborate.
  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

`ifdef VS_UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HI
  } state_t;
`endif

  logic             r_sync1;
  logic             r_sync2;
  logic             w_rxs;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_phase;
  logic [2:0]       r_bitcnt;
  logic [7:0]       r_shift;
  logic             r_strobe;
  logic [9:0]       r_data;
  logic             r_busy;
  logic             w_tick;
  logic             w_sample;
  logic             w_par_err;

`ifdef VS_UART_RX_PARITY_EN
  logic             r_par_err;
  assign w_par_err = r_par_err;
`else
  assign w_par_err = 1'b0;
`endif

  // Synchroniser: resets to the idle-line level, so that a reset does not
  // look like a start edge.
  always_ff @(posedge CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RXD;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // The divider is held at 0 while idle. It therefore restarts from 0 on the
  // clock that leaves IDLE, and the first tick comes DIV clocks later.
  assign w_tick   = (r_state != S_IDLE) && (r_div == DIV_MAX);
  assign w_sample = w_tick && (r_phase == 4'd7);

  // Receiver FSM. Counters, the shift register and all outputs are in this
  // one registered block.
  always_ff @(posedge CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_phase   <= 4'd0;
      r_bitcnt  <= 3'd0;
      r_shift   <= 8'h00;
      r_strobe  <= 1'b0;
      r_data    <= 10'h000;
      r_busy    <= 1'b0;
`ifdef VS_UART_RX_PARITY_EN
      r_par_err <= 1'b0;
`endif
    end else begin
      r_strobe <= 1'b0;

      if ((r_state == S_IDLE) || w_tick) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end

      // The phase wraps modulo 16. After the start-bit check at phase 7,
      // every later sample therefore falls exactly 16 ticks after the last.
      if (w_tick) begin
        r_phase <= r_phase + 4'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_state  <= S_START;
            r_phase  <= 4'd0;
            r_bitcnt <= 3'd0;
            r_busy   <= 1'b1;
          end
        end

        S_START: begin
          if (w_sample) begin
            if (w_rxs) begin
              // Line went back high before mid start bit: treat it as a
              // glitch and drop it without a strobe.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_sample) begin
            r_shift  <= {w_rxs, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
`ifdef VS_UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end
        end

`ifdef VS_UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_sample) begin
            // Even parity: the XOR of the data bits and the parity bit
            // must be zero.
            r_par_err <= w_rxs ^ (^r_shift);
            r_state   <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (w_sample) begin
            // Every completed frame is reported, including errored ones.
            r_data   <= {~w_rxs, w_par_err, r_shift};
            r_strobe <= 1'b1;
            if (w_rxs) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_WAIT_HI;
            end
          end
        end

        S_WAIT_HI: begin
          // A low stop bit may be a break. Wait for the line to go high
          // again, so that the low level is not taken as a new start bit.
          if (w_rxs) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign RX_DATA_EN = r_strobe;
  assign RX_DATA    = r_data;
  assign RX_BUSY    = r_busy;

endmodule

// File: tb/tb_vs_uart_rx.sv
module tb_vs_uart_rx;

  localparam int CLK_FREQ = 16000000;
  localparam int BAUD     = 1000000;
  localparam int BIT_CLKS = 16;

`ifdef VS_UART_RX_PARITY_EN
  // Negedges from start edge to strobe: 2 sync + 1 to START + 8 to mid start
  // + 10 bits * 16 (8 data + parity + stop).
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  logic       CLK;
  logic       SYS_NRST;
  logic       RXD;
  logic       RX_DATA_EN;
  logic [9:0] RX_DATA;
  logic       RX_BUSY;

  int         tests_run;
  int         tests_failed;

  int         strobe_cnt;
  int         wide_cnt;
  logic       prev_en;
  logic [9:0] cap_q[$];
  time        strobe_t;
  time        t0;

  vs_uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .CLK        (CLK),
    .SYS_NRST   (SYS_NRST),
    .RXD        (RXD),
    .RX_DATA_EN (RX_DATA_EN),
    .RX_DATA    (RX_DATA),
    .RX_BUSY    (RX_BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Strobe monitor. It samples on the falling edge, away from the DUT's
  // active edge.
  initial begin
    strobe_cnt = 0;
    wide_cnt   = 0;
    prev_en    = 1'b0;
    strobe_t   = 0;
  end

  always @(negedge CLK) begin
    if (RX_DATA_EN === 1'b1) begin
      strobe_cnt++;
      cap_q.push_back(RX_DATA);
      strobe_t = $time;
      if (prev_en) wide_cnt++;
    end
    prev_en = (RX_DATA_EN === 1'b1);
  end

  // Drive one bit for a full bit period. The caller is at a negedge.
  task automatic send_bit(input logic v);
    RXD = v;
    repeat (BIT_CLKS) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    t0 = $time;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef VS_UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) RXD = 1'b1;
`endif
    send_bit(stp);
  endtask

  task automatic test_reset();
    SYS_NRST = 1'b0;
    RXD      = 1'b1;
    repeat (3) @(negedge CLK);
    tests_run++;
    if (RX_DATA !== 10'h000) begin
      tests_failed++;
      $display("FAIL reset_data got=%h exp=%h", RX_DATA, 10'h000);
    end
    tests_run++;
    if (RX_DATA_EN !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_en got=%b exp=0", RX_DATA_EN);
    end
    // A low line during reset must not start a frame.
    RXD = 1'b0;
    repeat (4) @(negedge CLK);
    tests_run++;
    if (RX_BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy got=%b exp=0", RX_BUSY);
    end
    RXD = 1'b1;
    repeat (4) @(negedge CLK);
    SYS_NRST = 1'b1;
    repeat (5) @(negedge CLK);
    tests_run++;
    if (RX_BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_busy got=%b exp=0", RX_BUSY);
    end
  endtask

  task automatic test_basic();
    int  n0;
    longint lat;
    n0 = strobe_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (20) @(negedge CLK);
    tests_run++;
    if (strobe_cnt - n0 !== 1) begin
      tests_failed++;
      $display("FAIL basic_count got=%0d exp=1", strobe_cnt - n0);
    end
    tests_run++;
    if (RX_DATA !== 10'h0A5) begin
      tests_failed++;
      $display("FAIL basic_data got=%h exp=%h", RX_DATA, 10'h0A5);
    end
    lat = longint'((strobe_t - t0) / 10);
    tests_run++;
    if (lat != LAT) begin
      tests_failed++;
      $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT);
    end
  endtask

  task automatic test_parity_err();
    int n0;
    logic [9:0] exp;
`ifdef VS_UART_RX_PARITY_EN
    exp = 10'h101;
`else
    exp = 10'h001;
`endif
    n0 = strobe_cnt;
    send_frame(8'h01, 1'b0, 1'b1);
    repeat (20) @(negedge CLK);
    tests_run++;
    if (strobe_cnt - n0 !== 1) begin
      tests_failed++;
      $display("FAIL parity_count got=%0d exp=1", strobe_cnt - n0);
    end
    tests_run++;
    if (RX_DATA !== exp) begin
      tests_failed++;
      $display("FAIL parity_data got=%h exp=%h", RX_DATA, exp);
    end
  endtask

  task automatic test_frame_err();
    int n0;
    n0 = strobe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge CLK);
    tests_run++;
    if (RX_BUSY !== 1'b1) begin
      tests_failed++;
      $display("FAIL frame_busy_low got=%b exp=1", RX_BUSY);
    end
    tests_run++;
    if (strobe_cnt - n0 !== 1) begin
      tests_failed++;
      $display("FAIL frame_count got=%0d exp=1", strobe_cnt - n0);
    end
    tests_run++;
    if (RX_DATA !== 10'h23C) begin
      tests_failed++;
      $display("FAIL frame_data got=%h exp=%h", RX_DATA, 10'h23C);
    end
    RXD = 1'b1;
    repeat (8) @(negedge CLK);
    tests_run++;
    if (RX_BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_busy_release got=%b exp=0", RX_BUSY);
    end
    repeat (30) @(negedge CLK);
    tests_run++;
    if (strobe_cnt - n0 !== 1) begin
      tests_failed++;
      $display("FAIL frame_no_second got=%0d exp=1", strobe_cnt - n0);
    end
  endtask

  task automatic test_glitch();
    int n0;
    n0 = strobe_cnt;
    RXD = 1'b0;
    repeat (5) @(negedge CLK);
    RXD = 1'b1;
    tests_run++;
    if (RX_BUSY !== 1'b1) begin
      tests_failed++;
      $display("FAIL glitch_busy_set got=%b exp=1", RX_BUSY);
    end
    repeat (15) @(negedge CLK);
    tests_run++;
    if (RX_BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_busy_clear got=%b exp=0", RX_BUSY);
    end
    repeat (200) @(negedge CLK);
    tests_run++;
    if (strobe_cnt - n0 !== 0) begin
      tests_failed++;
      $display("FAIL glitch_count got=%0d exp=0", strobe_cnt - n0);
    end
  endtask

  task automatic test_back_to_back();
    cap_q.delete();
    send_frame(8'h55, 1'b0, 1'b1);
    send_frame(8'hAA, 1'b0, 1'b1);
    repeat (30) @(negedge CLK);
    tests_run++;
    if (cap_q.size() !== 2) begin
      tests_failed++;
      $display("FAIL b2b_count got=%0d exp=2", cap_q.size());
    end else begin
      tests_run++;
      if (cap_q[0] !== 10'h055) begin
        tests_failed++;
        $display("FAIL b2b_first got=%h exp=%h", cap_q[0], 10'h055);
      end
      tests_run++;
      if (cap_q[1] !== 10'h0AA) begin
        tests_failed++;
        $display("FAIL b2b_second got=%h exp=%h", cap_q[1], 10'h0AA);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    logic [7:0] part;
    part = 8'h5A;
    n0 = strobe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(part[i]);
    RXD = part[4];
    repeat (8) @(negedge CLK);
    SYS_NRST = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (RX_DATA !== 10'h000) begin
      tests_failed++;
      $display("FAIL rstmid_data got=%h exp=%h", RX_DATA, 10'h000);
    end
    tests_run++;
    if (RX_BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_busy got=%b exp=0", RX_BUSY);
    end
    repeat (2) @(negedge CLK);
    SYS_NRST = 1'b1;
    RXD = 1'b1;
    repeat (200) @(negedge CLK);
    tests_run++;
    if (strobe_cnt - n0 !== 0) begin
      tests_failed++;
      $display("FAIL rstmid_count got=%0d exp=0", strobe_cnt - n0);
    end
    tests_run++;
    if (RX_DATA !== 10'h000) begin
      tests_failed++;
      $display("FAIL rstmid_hold got=%h exp=%h", RX_DATA, 10'h000);
    end
    send_frame(8'h7E, 1'b0, 1'b1);
    repeat (20) @(negedge CLK);
    tests_run++;
    if (strobe_cnt - n0 !== 1) begin
      tests_failed++;
      $display("FAIL rstmid_next_count got=%0d exp=1", strobe_cnt - n0);
    end
    tests_run++;
    if (RX_DATA !== 10'h07E) begin
      tests_failed++;
      $display("FAIL rstmid_next_data got=%h exp=%h", RX_DATA, 10'h07E);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    SYS_NRST     = 1'b0;
    RXD          = 1'b1;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_parity_err();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    tests_run++;
    if (wide_cnt !== 0) begin
      tests_failed++;
      $display("FAIL strobe_width got=%0d wide strobes exp=0", wide_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vs_uart_rx.md
VS_UART_RX -- requirements
Module: vs_uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate in bit/s.
REQ-003 Port CLK  input  1  system clock, all logic on rising edge.
REQ-004 Port SYS_NRST  input  1  reset, asynchronous, active-low.
REQ-005 Port RXD  input  1  asynchronous serial line, idle high.
REQ-006 Port RX_DATA_EN  output  1  one-CLK strobe: RX_DATA holds a new frame.
REQ-007 Port RX_DATA  output  10  {FRM_ERR, PAR_ERR, DATA[7:0]}, bit 9 = stop-bit error, bit 8 = parity error.
REQ-008 Port RX_BUSY  output  1  high while not in IDLE.

Function
REQ-009 RXD SHALL pass a 2-flop synchronizer (reset value 1); all decisions use the synchronized value RXS.
REQ-010 Oversample tick SHALL fire every DIV = CLK_FREQ/(BAUD*16) CLKs (integer division, DIV >= 1); the divider restarts at 0 on the IDLE->START transition.
REQ-011 A 4-bit tick counter SHALL index the 16 sub-bit phases; the mid-bit sample is taken at phase 7.
REQ-012 States: IDLE, START, DATA, PARITY, STOP, WAIT_HI.
REQ-013 IDLE: RXS=0 -> START, and the tick and bit counters clear.
REQ-014 START: at phase 7, RXS=1 -> IDLE (glitch rejected, no strobe); RXS=0 -> DATA, with the phase realigned so the next sample falls 16 ticks later.
REQ-015 DATA: sample once per 16 ticks, LSB first, into a shift register; after the 8th bit -> PARITY if the parity feature is compiled in, else -> STOP.
REQ-016 PARITY: sampled bit XOR (XOR of DATA[7:0]) != 0 sets PAR_ERR (even parity) -> STOP.
REQ-017 STOP: sampled RXS=0 sets FRM_ERR -> WAIT_HI; RXS=1 -> IDLE.
REQ-018 WAIT_HI: remain until RXS=1, then -> IDLE (break and line-low do not retrigger).
REQ-019 RX_DATA SHALL update and RX_DATA_EN pulse high for exactly 1 CLK, one CLK after the stop-bit sample, for every completed frame including errored frames.
REQ-020 RX_DATA SHALL hold its value between strobes; errors are never silently dropped.
REQ-021 Back-to-back frames: a start edge on the CLK after returning to IDLE SHALL be accepted; there is no dead time beyond the stop-bit half-period.
REQ-022 RX_BUSY SHALL be low only in IDLE.

Reset
REQ-023 While SYS_NRST=0: state=IDLE, RX_DATA=10'h000, RX_DATA_EN=0, RX_BUSY=0, all counters 0, synchronizer flops=1.
REQ-024 A reset asserted mid-frame SHALL abort the frame without a strobe; after release, reception resumes at the next falling edge.

Configuration
REQ-025 Macro VS_UART_RX_PARITY_EN defined: frame format 8E1, the PARITY state exists, and RX_DATA[8] reports the parity result.
REQ-026 Macro VS_UART_RX_PARITY_EN undefined: frame format 8N1, the PARITY state is absent, RX_DATA[8] is tied to 0, and STOP follows DATA directly.

Verification (CLK_FREQ=16000000, BAUD=1000000 -> 16 CLK/bit)
REQ-027 Byte 8'hA5 sent 8E1 with parity 0 and stop 1 -> one strobe, RX_DATA=10'h0A5, strobe at 1 CLK after the mid-stop sample (about 10.5 bit times plus 2 sync CLKs after the start edge).
REQ-028 Byte 8'h01 sent with parity bit 0 (wrong) -> RX_DATA=10'h101, one strobe.
REQ-029 Byte 8'h3C sent with stop bit 0, line then held low for 40 CLKs -> RX_DATA=10'h23C, one strobe, RX_BUSY stays high until RXD returns to 1, no second strobe.
REQ-030 Low pulse of 5 CLKs on an idle line -> no strobe, RX_BUSY returns to 0 at about 10 CLKs.
REQ-031 Frames 8'h55 and 8'hAA sent back-to-back with no idle gap -> two strobes with RX_DATA 10'h055 then 10'h0AA.
REQ-032 SYS_NRST pulsed low during bit 4 of a frame -> no strobe, RX_DATA=10'h000; the next full frame 8'h7E -> 10'h07E.
